flags_unit: RTL and testbench

Parametrised condition-flag unit for the pipelined CPU's execute/writeback boundary. It registers carry, logic-carry, zero, sign and overflow flags from a WIDTH-bit ALU result, with per-flag write masking and add/sub-aware overflow. It adds a LIFO flag stack so interrupt entry and return can save and restore the complete flag state in one cycle each. It supersedes the fixed 8-bit, always-updating flag register.

---
 rtl/flags_unit.sv | 145 ++++++++++++++
 tb/tb_flags_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/flags_unit.sv
// flags_unit: registered condition flags for the execute/writeback boundary, with a
// LIFO flag stack for single-cycle save/restore on interrupt entry and return.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   flag_we, flag_mask    flag update strobe and per-flag enables
//                         ([0] arith_carry [1] logic_carry [2] zero [3] sign [4] overflow)
//   is_sub                selects the subtraction overflow rule
//   data_in               ALU result
//   lhs_in, rhs_in        ALU operands (only the MSBs matter)
//   arith_carry_in,
//   logic_carry_in        carries from the ALU
//   carry_select_in       carry-source select, delayed alongside the flags
//   push, pop             flag-stack save / restore requests
//   err_clr               clears the sticky stack_err
//   arith_carry .. overflow, carry_select_d   registered flag word
//   stack_empty, stack_full, stack_err        stack status
//
// Flag word layout: {carry_select_d, overflow, sign, zero, logic_carry, arith_carry}.
module flags_unit #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flag_we,
   input  logic [4:0]       flag_mask,
   input  logic             is_sub,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] lhs_in,
   input  logic [WIDTH-1:0] rhs_in,
   input  logic             arith_carry_in,
   input  logic             logic_carry_in,
   input  logic [1:0]       carry_select_in,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clr,
   output logic             arith_carry,
   output logic             logic_carry,
   output logic             zero,
   output logic             sign,
   output logic             overflow,
   output logic [1:0]       carry_select_d,
   output logic             stack_empty,
   output logic             stack_full,
   output logic             stack_err
);

   localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [4:0]      flags_q, flags_d;
   logic [1:0]      csel_q, csel_d;
   logic [CntW-1:0] count_q, count_d;
   logic            err_q, err_d;
   logic [6:0]      stack_q [STACK_DEPTH];

   logic            empty, full;
   logic            push_eff, pop_eff, err_set;
   logic [CntW-1:0] cnt_m1;
   logic [IdxW-1:0] wr_idx, rd_idx;
   logic            msb_l, msb_r, msb_d, ovf;

   // Only the operand MSBs feed the overflow rules.
   logic unused_opnd;
   assign unused_opnd = ^{lhs_in[WIDTH-2:0], rhs_in[WIDTH-2:0]};

   assign empty  = (count_q == '0);
   assign full   = (count_q == CntW'(STACK_DEPTH));
   assign cnt_m1 = count_q - CntW'(1);
   assign wr_idx = count_q[IdxW-1:0];
   assign rd_idx = cnt_m1[IdxW-1:0];

   // push and pop together cancel: nothing on the stack side happens.
   assign push_eff = push & ~pop & ~full;
   assign pop_eff  = pop & ~push & ~empty;
   assign err_set  = (push & ~pop & full) | (pop & ~push & empty);

   assign msb_l = lhs_in[WIDTH-1];
   assign msb_r = rhs_in[WIDTH-1];
   assign msb_d = data_in[WIDTH-1];
   assign ovf   = is_sub ? ((msb_l ^ msb_r) & (msb_l ^ msb_d))
                         : ((msb_l ^ msb_d) & (msb_d ^ msb_r));

   always_comb begin
      flags_d = flags_q;
      csel_d  = csel_q;
      // A successful restore overrides any ALU update in the same cycle.
      if (pop_eff) begin
         {csel_d, flags_d} = stack_q[rd_idx];
      end else if (flag_we) begin
         csel_d = carry_select_in;
         if (flag_mask[0]) flags_d[0] = arith_carry_in;
         if (flag_mask[1]) flags_d[1] = logic_carry_in;
         if (flag_mask[2]) flags_d[2] = (data_in == '0);
         if (flag_mask[3]) flags_d[3] = msb_d;
         if (flag_mask[4]) flags_d[4] = ovf;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push_eff)     count_d = count_q + CntW'(1);
      else if (pop_eff) count_d = cnt_m1;
   end

   // A new error outranks a same-cycle clear.
   always_comb begin
      err_d = err_q;
      if (err_set)      err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= '0;
         csel_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         csel_q  <= csel_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Stack contents are not reset; push saves the pre-update flag word.
   always_ff @(posedge clk) begin
      if (rst_n && push_eff) begin
         stack_q[wr_idx] <= {csel_q, flags_q};
      end
   end

   assign arith_carry    = flags_q[0];
   assign logic_carry    = flags_q[1];
   assign zero           = flags_q[2];
   assign sign           = flags_q[3];
   assign overflow       = flags_q[4];
   assign carry_select_d = csel_q;
   assign stack_empty    = empty;
   assign stack_full     = full;
   assign stack_err      = err_q;

endmodule

// File: tb/tb_flags_unit.sv
// Directed self-checking bench for flags_unit (WIDTH=8, STACK_DEPTH=4).
// Flag word F = {carry_select_d, overflow, sign, zero, logic_carry, arith_carry};
// status word S = {stack_err, stack_full, stack_empty}.
module tb_flags_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flag_we;
   logic [4:0] flag_mask;
   logic       is_sub;
   logic [7:0] data_in, lhs_in, rhs_in;
   logic       arith_carry_in, logic_carry_in;
   logic [1:0] carry_select_in;
   logic       push, pop, err_clr;
   logic       arith_carry, logic_carry, zero, sign, overflow;
   logic [1:0] carry_select_d;
   logic       stack_empty, stack_full, stack_err;

   int n_checks = 0;
   int n_pass   = 0;

   flags_unit #(
      .WIDTH      (8),
      .STACK_DEPTH(4)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flag_we        (flag_we),
      .flag_mask      (flag_mask),
      .is_sub         (is_sub),
      .data_in        (data_in),
      .lhs_in         (lhs_in),
      .rhs_in         (rhs_in),
      .arith_carry_in (arith_carry_in),
      .logic_carry_in (logic_carry_in),
      .carry_select_in(carry_select_in),
      .push           (push),
      .pop            (pop),
      .err_clr        (err_clr),
      .arith_carry    (arith_carry),
      .logic_carry    (logic_carry),
      .zero           (zero),
      .sign           (sign),
      .overflow       (overflow),
      .carry_select_d (carry_select_d),
      .stack_empty    (stack_empty),
      .stack_full     (stack_full),
      .stack_err      (stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] fword();
      return {carry_select_d, overflow, sign, zero, logic_carry, arith_carry};
   endfunction

   function automatic logic [2:0] sword();
      return {stack_err, stack_full, stack_empty};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one edge and settle away from it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst_n   = 1'b1;
      flag_we = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic set_alu(input logic [4:0] mask, input logic sub, input logic [7:0] l,
                          input logic [7:0] r, input logic [7:0] d, input logic ac,
                          input logic lc, input logic [1:0] cs);
      flag_we         = 1'b1;
      flag_mask       = mask;
      is_sub          = sub;
      lhs_in          = l;
      rhs_in          = r;
      data_in         = d;
      arith_carry_in  = ac;
      logic_carry_in  = lc;
      carry_select_in = cs;
   endtask

   initial begin
      idle();
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd3);

      // Reset wins over flag_we and push.
      rst_n = 1'b0;
      push  = 1'b1;
      cyc();
      check("reset_flags", fword(), 7'h00);
      check("reset_status", sword(), 3'b001);
      idle();

      // Overflow rules.
      set_alu(5'h1F, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 2'd0);
      cyc(); idle();
      check("add_ovf", fword(), 7'h18);
      set_alu(5'h1F, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 2'd1);
      cyc(); idle();
      check("sub_ovf", fword(), 7'h31);
      set_alu(5'h1F, 1'b1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 2'd2);
      cyc(); idle();
      check("sub_zero", fword(), 7'h46);

      // Masking.
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 2'd0);
      cyc(); idle();
      check("clear_flags", fword(), 7'h00);
      set_alu(5'h1C, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd3);
      cyc(); idle();
      check("mask_1c", fword(), 7'h64);
      data_in = 8'h80;
      cyc();
      check("hold_we0", fword(), 7'h64);

      // Fill the stack with four distinct words.
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0);
      cyc(); idle();
      check("e0_val", fword(), 7'h05);
      push = 1'b1; cyc(); idle();
      check("push1_status", sword(), 3'b000);
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 2'd1);
      cyc(); idle();
      check("e1_val", fword(), 7'h22);
      push = 1'b1; cyc(); idle();
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0, 2'd2);
      cyc(); idle();
      check("e2_val", fword(), 7'h58);
      push = 1'b1; cyc(); idle();
      check("push3_status", sword(), 3'b000);
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h80, 1'b1, 1'b1, 2'd3);
      cyc(); idle();
      check("e3_val", fword(), 7'h7B);
      push = 1'b1; cyc(); idle();
      check("full_status", sword(), 3'b010);
      push = 1'b1; cyc(); idle();
      check("overflow_err", sword(), 3'b110);

      // Scramble the live flags so each restore is visible.
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 2'd0);
      cyc(); idle();
      check("scramble", fword(), 7'h00);

      pop = 1'b1; cyc();
      check("pop1_val", fword(), 7'h7B);
      check("pop1_status", sword(), 3'b100);
      cyc();
      check("pop2_val", fword(), 7'h58);
      cyc();
      check("pop3_val", fword(), 7'h22);
      cyc(); idle();
      check("pop4_val", fword(), 7'h05);
      check("drained_status", sword(), 3'b101);
      pop = 1'b1; cyc(); idle();
      check("underflow_val", fword(), 7'h05);
      check("underflow_status", sword(), 3'b101);
      err_clr = 1'b1; cyc(); idle();
      check("err_clr", sword(), 3'b001);
      // Error and clear together: error wins.
      pop = 1'b1; err_clr = 1'b1; cyc(); idle();
      check("err_beats_clr", sword(), 3'b101);
      err_clr = 1'b1; cyc(); idle();
      check("err_clr2", sword(), 3'b001);

      // push + flag_we: pre-update word (sign=0) is saved.
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0, 2'd0);
      push = 1'b1; cyc(); idle();
      check("push_we_val", fword(), 7'h18);
      check("push_we_status", sword(), 3'b000);
      // pop + flag_we: restore wins.
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1, 2'd3);
      pop = 1'b1; cyc(); idle();
      check("pop_we_val", fword(), 7'h05);
      check("pop_we_status", sword(), 3'b001);

      // push + pop: stack untouched, flag_we still applies.
      push = 1'b1; cyc(); idle();
      set_alu(5'h1F, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2'd2);
      push = 1'b1; pop = 1'b1; cyc(); idle();
      check("pushpop_val", fword(), 7'h46);
      check("pushpop_status", sword(), 3'b000);
      pop = 1'b1; cyc(); idle();
      check("pushpop_restore", fword(), 7'h05);

      // Reset mid-sequence.
      push = 1'b1; cyc(); cyc(); idle();
      check("two_push_status", sword(), 3'b000);
      rst_n = 1'b0; pop = 1'b1; cyc(); idle();
      check("midreset_flags", fword(), 7'h00);
      check("midreset_status", sword(), 3'b001);
      pop = 1'b1; cyc(); idle();
      check("post_reset_pop_flags", fword(), 7'h00);
      check("post_reset_pop_status", sword(), 3'b101);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
